// File: rtl/apb4_master.sv
// apb4_master
// Bridges single-beat valid/ready requests onto an APB4 bus shared by NUM_SLV
// slaves. The top SEL_W address bits pick the slave. Each transfer returns one
// response pulse carrying read data, slave error and timeout status.
//
// Ports
//   i_clk, i_reset_n          clock, async active-low reset
//   i_req_valid/o_req_ready   request handshake (ready is combinational)
//   i_addr/i_write/i_wdata/i_wstrb/i_prot   request fields
//   o_rsp_valid               one-cycle response pulse
//   o_rdata/o_err/o_timeout   response fields, held until the next response
//   PADDR..PENABLE, PSEL      APB4 master outputs (PSEL is one-hot)
//   PRDATA/PREADY/PSLVERR     per-slave APB4 inputs, slave k in lane k
//
// state  | meaning
// IDLE   | no transfer; ready for a request
// SETUP  | PSEL high, PENABLE low; one cycle
// ACCESS | PENABLE high; waiting on selected PREADY or timeout
module apb4_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16,
    localparam int STRB_W = DATA_W / 8,
    localparam int SEL_W  = $clog2(NUM_SLV)
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic                      i_write,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [STRB_W-1:0]         i_wstrb,
    input  logic [2:0]                i_prot,
    output logic                      o_rsp_valid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_err,
    output logic                      o_timeout,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [STRB_W-1:0]         PSTRB,
    output logic [2:0]                PPROT,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [2:0]          pprot_q;
    logic                penable_q;
    logic [NUM_SLV-1:0]  psel_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                timeout_q;

    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   prdata_sel;
    logic                tmo_fire;
    logic                done;
    logic                accept;
    logic [SEL_W-1:0]    req_idx;
    logic [NUM_SLV-1:0]  req_onehot;

    assign pready_sel  = PREADY[sel_q];
    assign pslverr_sel = PSLVERR[sel_q];
    assign prdata_sel  = PRDATA[sel_q*DATA_W +: DATA_W];

    assign req_idx    = i_addr[ADDR_W-1 -: SEL_W];
    assign req_onehot = {{(NUM_SLV-1){1'b0}}, 1'b1} << req_idx;

    // PREADY in the same cycle as the last allowed count beats the abort.
    assign tmo_fire = (TIMEOUT != 0) && (state_q == ACCESS) && !pready_sel
                      && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:   if (i_req_valid) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready_sel || tmo_fire) begin
                    done    = 1'b1;
                    state_d = i_req_valid ? SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_req_ready = i_reset_n && ((state_q == IDLE) || done);
    assign accept      = i_req_valid && o_req_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            penable_q <= (state_d == ACCESS);

            if (accept) begin
                paddr_q  <= i_addr;
                pwrite_q <= i_write;
                pprot_q  <= i_prot;
                psel_q   <= req_onehot;
                sel_q    <= req_idx;
                pwdata_q <= i_write ? i_wdata : '0;
                pstrb_q  <= i_write ? i_wstrb : '0;
            end else if (done) begin
                psel_q <= '0;
            end

            // Every ACCESS is entered from SETUP, so clearing there suffices.
            if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS && !pready_sel) begin
                cnt_q <= cnt_q + 1'b1;
            end

            rsp_valid_q <= done;
            if (done) begin
                rdata_q   <= (tmo_fire || pwrite_q) ? '0 : prdata_sel;
                err_q     <= tmo_fire ? 1'b1 : pslverr_sel;
                timeout_q <= tmo_fire;
            end
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign PENABLE     = penable_q;
    assign PSEL        = psel_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
module tb_apb4_master;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_addr;
    logic        i_write;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic [2:0]  i_prot;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [127:0] PRDATA;
    logic [3:0]  PREADY;
    logic [3:0]  PSLVERR;

    apb4_master #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_addr(i_addr), .i_write(i_write), .i_wdata(i_wdata),
        .i_wstrb(i_wstrb), .i_prot(i_prot),
        .o_rsp_valid(o_rsp_valid), .o_rdata(o_rdata), .o_err(o_err),
        .o_timeout(o_timeout),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    // Slave model: fixed read data per slave, wait states counted in ACCESS.
    int         wait_n[4];
    logic [3:0] err_v;
    int         wcnt;

    assign PRDATA  = {32'h1234_5678, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    assign PSLVERR = err_v;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                          wcnt <= 0;
        else if (PENABLE && !(|(PSEL & PREADY))) wcnt <= wcnt + 1;
        else                                     wcnt <= 0;
    end

    always_comb begin
        PREADY = '0;
        for (int k = 0; k < 4; k++) PREADY[k] = (wcnt >= wait_n[k]);
    end

    // Transfer-shape counters for the back-to-back window.
    logic cnt_en = 1'b0;
    int   setup_cycles = 0;
    int   access_cycles = 0;
    always @(negedge i_clk) begin
        if (cnt_en && PSEL != 0 && !PENABLE) setup_cycles <= setup_cycles + 1;
        if (cnt_en && PSEL != 0 &&  PENABLE) access_cycles <= access_cycles + 1;
    end

    // Response monitor.
    always @(negedge i_clk) begin
        if (i_reset_n && o_rsp_valid) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b tmo=%b at cyc %0d, required no response",
                         o_rdata, o_err, o_timeout, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (o_rdata !== e.rdata || o_err !== e.err || o_timeout !== e.tmo || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rsp: got rdata=%h err=%b tmo=%b cyc=%0d, required rdata=%h err=%b tmo=%b cyc=%0d",
                             o_rdata, o_err, o_timeout, cyc, e.rdata, e.err, e.tmo, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drives a request at a negedge and returns right after the accept edge.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input int waits,
                          input logic [31:0] exp_rd, input logic exp_err, input logic exp_tmo,
                          output int acc);
        @(negedge i_clk);
        i_addr = a; i_write = w; i_wdata = d; i_wstrb = s; i_prot = p;
        i_req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (o_req_ready) break;
            @(negedge i_clk);
        end
        chk("req_accept", {63'd0, o_req_ready}, 64'd1);
        acc = cyc + 1;
        sb_q.push_back('{exp_rd, exp_err, exp_tmo, acc + 2 + waits});
        @(posedge i_clk);
    endtask

    task automatic go_idle();
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, required finish before 20000");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int a_b2b[4];

        i_reset_n = 1'b0;
        i_req_valid = 1'b0;
        i_addr = '0; i_write = 1'b0; i_wdata = '0; i_wstrb = '0; i_prot = '0;
        err_v = '0;
        for (int k = 0; k < 4; k++) wait_n[k] = 0;

        #3;
        chk("rst_psel",    {60'd0, PSEL}, 64'd0);
        chk("rst_penable", {63'd0, PENABLE}, 64'd0);
        chk("rst_paddr",   {32'd0, PADDR}, 64'd0);
        chk("rst_ready",   {63'd0, o_req_ready}, 64'd0);
        chk("rst_rsp",     {31'd0, o_rsp_valid, o_rdata}, 64'd0);
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;

        // Zero-wait write to slave 1.
        do_req(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b101, 0, 32'h0, 1'b0, 1'b0, acc);
        go_idle();
        chk("wr_setup_psel",    {60'd0, PSEL}, 64'h2);
        chk("wr_setup_penable", {63'd0, PENABLE}, 64'd0);
        chk("wr_pstrb",         {60'd0, PSTRB}, 64'hF);
        chk("wr_pwdata",        {32'd0, PWDATA}, 64'hDEAD_BEEF);
        chk("wr_pprot",         {61'd0, PPROT}, 64'h5);
        @(negedge i_clk);
        chk("wr_access_penable", {63'd0, PENABLE}, 64'd1);
        chk("wr_access_pwrite",  {63'd0, PWRITE}, 64'd1);

        // Read with 3 wait states from slave 3; bus stable through ACCESS.
        wait_n[3] = 3;
        do_req(32'hC000_0020, 1'b0, 32'h5555_AAAA, 4'hF, 3'b000, 3, 32'h1234_5678, 1'b0, 1'b0, acc);
        go_idle();
        chk("rd_setup_psel",    {60'd0, PSEL}, 64'h8);
        chk("rd_setup_pwdata",  {32'd0, PWDATA}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("rd_access_penable", {63'd0, PENABLE}, 64'd1);
            chk("rd_access_bus", {PSEL, PSTRB, PWRITE, 23'd0, PADDR}, {4'h8, 4'h0, 1'b0, 23'd0, 32'hC000_0020});
        end
        @(negedge i_clk);
        chk("rd_done_psel",    {60'd0, PSEL}, 64'd0);
        chk("rd_done_penable", {63'd0, PENABLE}, 64'd0);
        chk("rd_hold_paddr",   {32'd0, PADDR}, 64'hC000_0020);
        wait_n[3] = 0;

        // Slave error on a read from slave 2; slave 3 error must be ignored.
        err_v = 4'b0100;
        do_req(32'h8000_0004, 1'b0, 32'h0, 4'h0, 3'b010, 0, 32'hA5A5_0002, 1'b1, 1'b0, acc);
        go_idle();
        repeat (3) @(negedge i_clk);
        err_v = 4'b1000;
        do_req(32'h8000_0008, 1'b0, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5_0002, 1'b0, 1'b0, acc);
        go_idle();
        repeat (3) @(negedge i_clk);
        err_v = '0;

        // Timeout on slave 1, PREADY never rises.
        wait_n[1] = 255;
        do_req(32'h4000_0040, 1'b0, 32'h0, 4'h0, 3'b000, 15, 32'h0, 1'b1, 1'b1, acc);
        go_idle();
        repeat (17) @(negedge i_clk);
        chk("tmo_psel",    {60'd0, PSEL}, 64'd0);
        chk("tmo_penable", {63'd0, PENABLE}, 64'd0);
        repeat (2) @(negedge i_clk);

        // PREADY on the 16th ACCESS cycle wins over the timeout.
        wait_n[1] = 15;
        do_req(32'h4000_0044, 1'b0, 32'h0, 4'h0, 3'b000, 15, 32'hA5A5_0001, 1'b0, 1'b0, acc);
        go_idle();
        repeat (19) @(negedge i_clk);
        wait_n[1] = 0;

        // Back-to-back, alternating slaves 0 and 1.
        cnt_en = 1'b1;
        do_req(32'h0000_0000, 1'b1, 32'h1111_1111, 4'h3, 3'b000, 0, 32'h0, 1'b0, 1'b0, a_b2b[0]);
        do_req(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5_0001, 1'b0, 1'b0, a_b2b[1]);
        do_req(32'h0000_0004, 1'b1, 32'h2222_2222, 4'hC, 3'b000, 0, 32'h0, 1'b0, 1'b0, a_b2b[2]);
        do_req(32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5_0001, 1'b0, 1'b0, a_b2b[3]);
        go_idle();
        repeat (4) @(negedge i_clk);
        cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) chk("b2b_spacing", 64'(a_b2b[i+1] - a_b2b[i]), 64'd2);
        chk("b2b_setup_cycles",  64'(setup_cycles), 64'd4);
        chk("b2b_access_cycles", 64'(access_cycles), 64'd4);

        // Reset during ACCESS: transfer dropped, outputs cleared at once.
        wait_n[0] = 255;
        do_req(32'h0000_0100, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b111, 0, 32'h0, 1'b0, 1'b0, acc);
        go_idle();
        repeat (3) @(negedge i_clk);
        #2;
        i_reset_n = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_psel",    {60'd0, PSEL}, 64'd0);
        chk("mid_rst_penable", {63'd0, PENABLE}, 64'd0);
        chk("mid_rst_bus",     {PADDR, PWDATA}, 64'd0);
        chk("mid_rst_ctl",     {57'd0, PSTRB, PPROT}, 64'd0);
        chk("mid_rst_rsp",     {29'd0, o_rsp_valid, o_err, o_timeout, o_rdata}, 64'd0);
        chk("mid_rst_ready",   {63'd0, o_req_ready}, 64'd0);
        wait_n[0] = 0;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        do_req(32'h0000_0200, 1'b0, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5_0000, 1'b0, 1'b0, acc);
        go_idle();
        repeat (4) @(negedge i_clk);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
